// File: rtl/min_sec_timebase_if.sv
// Bundle of front-panel controls and time outputs for min_sec_timebase.
// Ports (signals):
//   run        1  1 = time runs, 0 = adjust mode
//   adj_min_n  1  raw minute-adjust key, active-low, asynchronous
//   sec_clr_n  1  raw seconds-clear key, active-low, asynchronous
//   sec_bcd    8  seconds, BCD
//   min_bcd    8  minutes, BCD
//   sec_tick   1  one-cycle pulse per elapsed second
//   hour_inc   1  one-cycle enable to the hour counter on 59:59 -> 00:00
// The controller side (panel/testbench) uses the master modport; the
// time base itself uses the slave modport.
interface min_sec_timebase_if;
    logic       run;
    logic       adj_min_n;
    logic       sec_clr_n;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic       sec_tick;
    logic       hour_inc;

    modport master (
        output run, adj_min_n, sec_clr_n,
        input  sec_bcd, min_bcd, sec_tick, hour_inc
    );

    modport slave (
        input  run, adj_min_n, sec_clr_n,
        output sec_bcd, min_bcd, sec_tick, hour_inc
    );
endinterface

// File: rtl/min_sec_timebase.sv
// Time base and BCD seconds/minutes counters for the digital clock.
// A prescaler divides clk down to a 1 Hz sec_tick; seconds and minutes count
// in BCD and hour_inc pulses once on each 59:59 -> 00:00 rollover.
// Two front-panel keys are synchronized and debounced: adj_min (adds a minute,
// adjust mode only) and sec_clr (clears seconds and restarts the second).
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   bus    slave modport of min_sec_timebase_if (run, keys in; time, pulses out)
module min_sec_timebase #(
    parameter int CLK_HZ   = 50000000,
    parameter int DBNC_CYC = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    min_sec_timebase_if.slave  bus
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DBNC_CYC > 1) ? $clog2(DBNC_CYC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DBNC_CYC - 1);

    // key index 0 = adj_min, 1 = sec_clr
    logic [1:0]    key_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    logic [PW-1:0] presc;
    logic          sec_tick_q;
    logic          hour_inc_q;
    logic [7:0]    sec_q;
    logic [7:0]    min_q;
    logic [8:0]    sec_nxt;
    logic [8:0]    min_nxt;
    logic          adj_press;
    logic          clr_press;

    assign key_raw = {bus.sec_clr_n, bus.adj_min_n};

    // Two-flop synchronizer, then a stability filter: the debounced level only
    // follows the synchronized key after DBNC_CYC consecutive differing samples.
    // A press pulse is emitted together with the debounced 1 -> 0 change, so a
    // held key produces exactly one pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= deb[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign adj_press = press[0] & ~bus.run;
    assign clr_press = press[1];

    // A clear or a stopped clock both restart the second from zero and
    // suppress a wrap that would otherwise land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            sec_tick_q <= 1'b0;
        end else if (clr_press || !bus.run) begin
            presc      <= '0;
            sec_tick_q <= 1'b0;
        end else if (presc == PRE_LAST) begin
            presc      <= '0;
            sec_tick_q <= 1'b1;
        end else begin
            presc      <= presc + 1'b1;
            sec_tick_q <= 1'b0;
        end
    end

    // BCD increment modulo 60; bit 8 flags the 59 -> 00 wrap.
    // Out-of-range digits fall back to 0.
    function automatic logic [8:0] inc60(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        logic       wrap;
        ones = v[3:0];
        tens = v[7:4];
        wrap = 1'b0;
        if (ones > 4'd9) begin
            ones = 4'd0;
        end else if (ones == 4'd9) begin
            ones = 4'd0;
            if (tens >= 4'd5) begin
                wrap = (tens == 4'd5);
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        if (tens > 4'd5) begin
            tens = 4'd0;
        end
        return {wrap, tens, ones};
    endfunction

    assign sec_nxt = inc60(sec_q);
    assign min_nxt = inc60(min_q);

    // Counters advance on the edge that drops sec_tick, so hour_inc lines up
    // with the first cycle showing 00:00. A clear on that edge wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            hour_inc_q <= 1'b0;
        end else begin
            hour_inc_q <= 1'b0;
            if (clr_press) begin
                sec_q <= 8'h00;
            end else if (sec_tick_q) begin
                sec_q <= sec_nxt[7:0];
                if (sec_nxt[8]) begin
                    min_q      <= min_nxt[7:0];
                    hour_inc_q <= min_nxt[8];
                end
            end else if (adj_press) begin
                min_q <= min_nxt[7:0];
            end
        end
    end

    assign bus.sec_bcd  = sec_q;
    assign bus.min_bcd  = min_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.hour_inc = hour_inc_q;

endmodule

// File: tb/tb_min_sec_timebase.sv
// Self-checking bench for min_sec_timebase with CLK_HZ=10, DBNC_CYC=4.
// Expected time is derived from elapsed cycles and press counts with plain
// arithmetic (total seconds, div/mod 60, decimal-to-BCD).
module tb_min_sec_timebase;
    localparam int CLK_HZ   = 10;
    localparam int DBNC_CYC = 4;

    logic clk = 1'b0;
    logic reset;

    min_sec_timebase_if bus();

    min_sec_timebase #(.CLK_HZ(CLK_HZ), .DBNC_CYC(DBNC_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_min  = 0;
    int m_sec  = 0;
    int hinc_total = 0;
    int tick_total = 0;

    always @(posedge clk) begin
        #1;
        if (bus.hour_inc === 1'b1) hinc_total++;
        if (bus.sec_tick === 1'b1) tick_total++;
    end

    function automatic logic [7:0] to_bcd(input int v);
        int t;
        int o;
        t = v / 10;
        o = v % 10;
        return 8'((t << 4) | o);
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // which: 0 = adj_min key, 1 = sec_clr key
    task automatic press_key(input int which, input int low_len, input int high_len);
        if (which == 0) bus.adj_min_n = 1'b0;
        else            bus.sec_clr_n = 1'b0;
        repeat (low_len) cycle();
        bus.adj_min_n = 1'b1;
        bus.sec_clr_n = 1'b1;
        repeat (high_len) cycle();
    endtask

    task automatic adj_press_model();
        press_key(0, $urandom_range(6, 14), $urandom_range(8, 14));
        m_min = (m_min + 1) % 60;
    endtask

    task automatic clr_press_model();
        press_key(1, $urandom_range(6, 14), $urandom_range(8, 14));
        m_sec = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.run = 1'b0;
        bus.adj_min_n = 1'b1;
        bus.sec_clr_n = 1'b1;
        repeat (3) cycle();
        checks++; if (bus.sec_bcd !== 8'h00) begin errors++; $display("FAIL reset_sec: got %h expected 00", bus.sec_bcd); end
        checks++; if (bus.min_bcd !== 8'h00) begin errors++; $display("FAIL reset_min: got %h expected 00", bus.min_bcd); end
        checks++; if (bus.sec_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", bus.sec_tick); end
        checks++; if (bus.hour_inc !== 1'b0) begin errors++; $display("FAIL reset_hinc: got %b expected 0", bus.hour_inc); end
        reset = 1'b0;
        m_min = 0;
        m_sec = 0;
    endtask

    task automatic test_run_basic();
        int bad_tick = 0;
        int bad_time = 0;
        int h0 = hinc_total;
        int t0 = tick_total;
        bus.run = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            cycle();
            if (bus.sec_tick !== ((k % 10) == 0)) bad_tick++;
            if (bus.sec_bcd !== to_bcd((k - 1) / 10)) bad_time++;
        end
        cycle();
        bus.run = 1'b0;
        m_sec = 10;
        checks++; if (bad_tick !== 0) begin errors++; $display("FAIL run_tick_pattern: %0d bad cycles, expected 0", bad_tick); end
        checks++; if (bad_time !== 0) begin errors++; $display("FAIL run_sec_sequence: %0d bad cycles, expected 0", bad_time); end
        checks++; if (bus.sec_bcd !== 8'h10) begin errors++; $display("FAIL run_sec_after_10: got %h expected 10", bus.sec_bcd); end
        checks++; if (tick_total - t0 !== 10) begin errors++; $display("FAIL run_tick_count: got %0d expected 10", tick_total - t0); end
        checks++; if (hinc_total - h0 !== 0) begin errors++; $display("FAIL run_hinc_count: got %0d expected 0", hinc_total - h0); end
    endtask

    task automatic test_adjust_rollover();
        int bad_time = 0;
        int bad_h = 0;
        int tot;
        int h0;
        cycle();
        clr_press_model();
        h0 = hinc_total;
        for (int i = 0; i < 59; i++) adj_press_model();
        checks++; if (bus.min_bcd !== 8'h59 || bus.min_bcd !== to_bcd(m_min)) begin errors++; $display("FAIL adj_min_59: got %h expected 59", bus.min_bcd); end
        checks++; if (bus.sec_bcd !== to_bcd(m_sec)) begin errors++; $display("FAIL adj_sec_kept: got %h expected %h", bus.sec_bcd, to_bcd(m_sec)); end
        checks++; if (hinc_total - h0 !== 0) begin errors++; $display("FAIL adj_no_hinc: got %0d pulses expected 0", hinc_total - h0); end
        bus.run = 1'b1;
        for (int k = 1; k <= 605; k++) begin
            cycle();
            tot = (m_min * 60 + m_sec + (k - 1) / 10) % 3600;
            if (bus.sec_bcd !== to_bcd(tot % 60) || bus.min_bcd !== to_bcd(tot / 60)) bad_time++;
            if (bus.hour_inc !== (k == 601)) bad_h++;
            if (k == 600) begin
                checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h5959) begin errors++; $display("FAIL roll_5959: got %h expected 5959", {bus.min_bcd, bus.sec_bcd}); end
            end
            if (k == 601) begin
                checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0000) begin errors++; $display("FAIL roll_0000: got %h expected 0000", {bus.min_bcd, bus.sec_bcd}); end
                checks++; if (bus.hour_inc !== 1'b1) begin errors++; $display("FAIL roll_hinc: got %b expected 1", bus.hour_inc); end
            end
        end
        bus.run = 1'b0;
        m_min = 0;
        m_sec = 0;
        checks++; if (bad_time !== 0) begin errors++; $display("FAIL roll_sequence: %0d bad cycles, expected 0", bad_time); end
        checks++; if (bad_h !== 0) begin errors++; $display("FAIL roll_hinc_pattern: %0d bad cycles, expected 0", bad_h); end
        checks++; if (hinc_total - h0 !== 1) begin errors++; $display("FAIL roll_hinc_count: got %0d expected 1", hinc_total - h0); end
    endtask

    task automatic test_debounce();
        int m0;
        int hold;
        int t0;
        cycle();
        m0 = m_min;
        t0 = tick_total;
        press_key(0, $urandom_range(1, 3), 12);
        checks++; if (bus.min_bcd !== to_bcd(m0)) begin errors++; $display("FAIL dbnc_glitch: got %h expected %h", bus.min_bcd, to_bcd(m0)); end
        press_key(0, 8, 12);
        checks++; if (bus.min_bcd !== to_bcd(m0 + 1)) begin errors++; $display("FAIL dbnc_press: got %h expected %h", bus.min_bcd, to_bcd(m0 + 1)); end
        hold = $urandom_range(60, 100);
        bus.adj_min_n = 1'b0;
        repeat (20) cycle();
        checks++; if (bus.min_bcd !== to_bcd(m0 + 2)) begin errors++; $display("FAIL dbnc_hold_early: got %h expected %h", bus.min_bcd, to_bcd(m0 + 2)); end
        repeat (hold - 20) cycle();
        bus.adj_min_n = 1'b1;
        repeat (12) cycle();
        m_min = (m0 + 2) % 60;
        checks++; if (bus.min_bcd !== to_bcd(m_min)) begin errors++; $display("FAIL dbnc_hold_once: got %h expected %h", bus.min_bcd, to_bcd(m_min)); end
        checks++; if (bus.sec_bcd !== to_bcd(m_sec)) begin errors++; $display("FAIL dbnc_sec_kept: got %h expected %h", bus.sec_bcd, to_bcd(m_sec)); end
        checks++; if (tick_total - t0 !== 0) begin errors++; $display("FAIL dbnc_no_tick: got %0d ticks expected 0", tick_total - t0); end
    endtask

    task automatic test_clr_on_wrap();
        int n;
        int h0;
        int t0;
        n = (5 - m_min + 60) % 60;
        for (int i = 0; i < n; i++) adj_press_model();
        clr_press_model();
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0500) begin errors++; $display("FAIL clr_pre_state: got %h expected 0500", {bus.min_bcd, bus.sec_bcd}); end
        h0 = hinc_total;
        t0 = tick_total;
        bus.run = 1'b1;
        for (int k = 1; k <= 615; k++) begin
            cycle();
            if (k == 593) bus.sec_clr_n = 1'b0;
            if (k == 601) bus.sec_clr_n = 1'b1;
            if (k == 599) begin
                checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0559) begin errors++; $display("FAIL clr_reach_0559: got %h expected 0559", {bus.min_bcd, bus.sec_bcd}); end
            end
            if (k == 600) begin
                checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0500) begin errors++; $display("FAIL clr_wins_time: got %h expected 0500", {bus.min_bcd, bus.sec_bcd}); end
                checks++; if (bus.sec_tick !== 1'b0) begin errors++; $display("FAIL clr_wins_tick: got %b expected 0", bus.sec_tick); end
            end
            if (k == 601) begin
                checks++; if ({bus.min_bcd, bus.sec_bcd, bus.sec_tick} !== {16'h0500, 1'b0}) begin errors++; $display("FAIL clr_after: got %h/%b expected 0500/0", {bus.min_bcd, bus.sec_bcd}, bus.sec_tick); end
            end
            if (k == 610) begin
                checks++; if (bus.sec_tick !== 1'b1) begin errors++; $display("FAIL clr_restart_tick: got %b expected 1", bus.sec_tick); end
            end
        end
        bus.run = 1'b0;
        m_min = 5;
        m_sec = 1;
        checks++; if (hinc_total - h0 !== 0) begin errors++; $display("FAIL clr_no_hinc: got %0d expected 0", hinc_total - h0); end
        checks++; if (tick_total - t0 !== 60) begin errors++; $display("FAIL clr_tick_count: got %0d expected 60", tick_total - t0); end
        checks++; if (bus.sec_bcd !== to_bcd(m_sec)) begin errors++; $display("FAIL clr_final_sec: got %h expected %h", bus.sec_bcd, to_bcd(m_sec)); end
    endtask

    task automatic test_reset_mid();
        int n;
        int r;
        int bad_tick = 0;
        cycle();
        n = (12 - m_min + 60) % 60;
        for (int i = 0; i < n; i++) adj_press_model();
        clr_press_model();
        r = $urandom_range(1, 8);
        bus.run = 1'b1;
        repeat (340 + r) cycle();
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h1234) begin errors++; $display("FAIL rstmid_pre: got %h expected 1234", {bus.min_bcd, bus.sec_bcd}); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0000) begin errors++; $display("FAIL rstmid_time: got %h expected 0000", {bus.min_bcd, bus.sec_bcd}); end
        checks++; if ({bus.sec_tick, bus.hour_inc} !== 2'b00) begin errors++; $display("FAIL rstmid_pulses: got %b expected 00", {bus.sec_tick, bus.hour_inc}); end
        for (int k = 1; k <= 15; k++) begin
            cycle();
            if (bus.sec_tick !== (k == 10)) bad_tick++;
        end
        bus.run = 1'b0;
        m_min = 0;
        m_sec = 1;
        checks++; if (bad_tick !== 0) begin errors++; $display("FAIL rstmid_first_tick: %0d bad cycles, expected 0", bad_tick); end
        checks++; if (bus.sec_bcd !== to_bcd(m_sec)) begin errors++; $display("FAIL rstmid_sec: got %h expected %h", bus.sec_bcd, to_bcd(m_sec)); end
    endtask

    task automatic test_run_drop();
        int p_list[3];
        p_list[0] = 7;
        p_list[1] = 9;
        p_list[2] = $urandom_range(1, 9);
        for (int j = 0; j < 3; j++) begin
            int bad_hold = 0;
            int bad_tick = 0;
            bus.run = 1'b0;
            cycle();
            bus.run = 1'b1;
            repeat (p_list[j]) cycle();
            bus.run = 1'b0;
            repeat (20) begin
                cycle();
                if (bus.sec_tick !== 1'b0) bad_hold++;
            end
            checks++; if (bad_hold !== 0 || bus.sec_bcd !== to_bcd(m_sec)) begin errors++; $display("FAIL drop_hold p=%0d: %0d ticks, sec %h expected 0 ticks, sec %h", p_list[j], bad_hold, bus.sec_bcd, to_bcd(m_sec)); end
            bus.run = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                cycle();
                if (bus.sec_tick !== (k == 10)) bad_tick++;
            end
            bus.run = 1'b0;
            m_sec = m_sec + 1;
            checks++; if (bad_tick !== 0) begin errors++; $display("FAIL drop_restart p=%0d: %0d bad cycles, expected 0", p_list[j], bad_tick); end
            checks++; if (bus.sec_bcd !== to_bcd(m_sec)) begin errors++; $display("FAIL drop_sec p=%0d: got %h expected %h", p_list[j], bus.sec_bcd, to_bcd(m_sec)); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.run = 1'b0;
        bus.adj_min_n = 1'b1;
        bus.sec_clr_n = 1'b1;
        test_reset();
        test_run_basic();
        test_adjust_rollover();
        test_debounce();
        test_clr_on_wrap();
        test_reset_mid();
        test_run_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
